// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port driven by the UART boot loader.
// The loader drives it through the master modport and the imem consumes it through slave.
interface uart_imem_loader_if #(
   parameter int ADDR_BITS = 9
);
   logic [ADDR_BITS-1:0] imem_write_address;
   logic [31:0]          imem_write_data;
   logic                 imem_write_enable;

   modport master (
      output imem_write_address,
      output imem_write_data,
      output imem_write_enable
   );

   modport slave (
      input imem_write_address,
      input imem_write_data,
      input imem_write_enable
   );
endinterface

// File: rtl/uart_imem_loader.sv
// UART (8N1) boot loader: A5, LEN_LO, LEN_HI, N little-endian words -> imem writes; holds the core meanwhile.
// Define UART_IMEM_LOADER_CHECKSUM_EN to expect a trailing mod-256 data checksum byte.
module uart_imem_loader #(
   parameter int CLOCK_HZ  = 27000000,
   parameter int BAUD      = 115200,
   parameter int ADDR_BITS = 9
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               uart_rx,
   uart_imem_loader_if.master imem,
   output logic               core_hold,
   output logic               load_done,
   output logic               load_error
);
   localparam int          DIV       = (CLOCK_HZ + BAUD / 2) / BAUD;
   localparam int          HALF      = DIV / 2;
   localparam int          CW        = $clog2(DIV + 1);
   localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_BITS;
   localparam logic [7:0]  SYNC      = 8'hA5;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERROR} state_t;

   rx_state_t      rx_state, rx_state_n;
   logic           rx_meta, rx_sync;
   logic [CW-1:0]  rx_cnt, rx_cnt_n;
   logic [2:0]     rx_bit, rx_bit_n;
   logic [7:0]     rx_shift, rx_shift_n;
   logic           byte_valid, frame_err;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
         rx_meta  <= uart_rx;
         rx_sync  <= rx_meta;
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_shift <= rx_shift_n;
      end
   end

   always_comb begin
      // NOTE: every output of a combinational block is defaulted first so no latch is inferred.
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_bit_n   = rx_bit;
      rx_shift_n = rx_shift;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_sync) begin
               rx_state_n = RX_START;
               rx_cnt_n   = '0;
            end
         end
         RX_START: begin
            if (rx_cnt == CW'(HALF - 1)) begin
               rx_cnt_n = '0;
               rx_bit_n = '0;
               // A line already back high at mid-start was only a glitch.
               rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_n = rx_cnt + CW'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt == CW'(DIV - 1)) begin
               rx_cnt_n   = '0;
               rx_shift_n = {rx_sync, rx_shift[7:1]};
               rx_bit_n   = rx_bit + 3'd1;
               if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            end else begin
               rx_cnt_n = rx_cnt + CW'(1);
            end
         end
         RX_STOP: begin
            if (rx_cnt == CW'(DIV - 1)) begin
               rx_cnt_n   = '0;
               rx_state_n = RX_IDLE;
               byte_valid = rx_sync;
               frame_err  = !rx_sync;
            end else begin
               rx_cnt_n = rx_cnt + CW'(1);
            end
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   state_t               state, state_n;
   logic [7:0]           len_lo, len_lo_n;
   logic [15:0]          remaining, remaining_n;
   logic [1:0]           byte_idx, byte_idx_n;
   logic [23:0]          word, word_n;
   logic [ADDR_BITS-1:0] addr, addr_n;
   logic [31:0]          wdata, wdata_n;
   logic                 we, we_n;
   logic                 hold, hold_n;
   logic                 done, done_n;
   logic                 err, err_n;
   logic [15:0]          len_word;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
   logic [7:0]           csum, csum_n;
`endif

   assign len_word = {rx_shift, len_lo};

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= S_IDLE;
         len_lo    <= '0;
         remaining <= '0;
         byte_idx  <= '0;
         word      <= '0;
         addr      <= '0;
         wdata     <= '0;
         we        <= 1'b0;
         hold      <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         state     <= state_n;
         len_lo    <= len_lo_n;
         remaining <= remaining_n;
         byte_idx  <= byte_idx_n;
         word      <= word_n;
         addr      <= addr_n;
         wdata     <= wdata_n;
         we        <= we_n;
         hold      <= hold_n;
         done      <= done_n;
         err       <= err_n;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
         csum      <= csum_n;
`endif
      end
   end

   always_comb begin
      state_n     = state;
      len_lo_n    = len_lo;
      remaining_n = remaining;
      byte_idx_n  = byte_idx;
      word_n      = word;
      addr_n      = addr;
      wdata_n     = wdata;
      we_n        = 1'b0;
      hold_n      = hold;
      done_n      = done;
      err_n       = err;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      csum_n      = csum;
`endif

      // Advance the address after the strobe, but never past the last word of the frame.
      if (we && remaining != '0) addr_n = addr + ADDR_BITS'(1);
`ifndef UART_IMEM_LOADER_CHECKSUM_EN
      // Without a checksum, release the core one cycle after the final write strobe.
      if (we && remaining == '0 && state == S_DATA) begin
         state_n = S_DONE;
         hold_n  = 1'b0;
         done_n  = 1'b1;
      end
`endif

      if (frame_err) begin
         if (state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM}) begin
            state_n = S_ERROR;
            err_n   = 1'b1;
            done_n  = 1'b0;
            hold_n  = 1'b1;
         end
      end else if (byte_valid) begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (rx_shift == SYNC) begin
                  state_n    = S_LEN_LO;
                  hold_n     = 1'b1;
                  done_n     = 1'b0;
                  err_n      = 1'b0;
                  addr_n     = '0;
                  byte_idx_n = '0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                  csum_n     = '0;
`endif
               end
            end
            S_LEN_LO: begin
               len_lo_n = rx_shift;
               state_n  = S_LEN_HI;
            end
            S_LEN_HI: begin
               if (33'(len_word) > MAX_WORDS) begin
                  state_n = S_ERROR;
                  err_n   = 1'b1;
                  hold_n  = 1'b1;
               end else if (len_word == 16'd0) begin
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                  state_n = S_CSUM;
`else
                  state_n = S_DONE;
                  hold_n  = 1'b0;
                  done_n  = 1'b1;
`endif
               end else begin
                  remaining_n = len_word;
                  byte_idx_n  = '0;
                  state_n     = S_DATA;
               end
            end
            S_DATA: begin
               byte_idx_n = byte_idx + 2'd1;
               word_n     = {rx_shift, word[23:8]};
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
               csum_n     = csum + rx_shift;
`endif
               if (byte_idx == 2'd3) begin
                  wdata_n     = {rx_shift, word};
                  we_n        = 1'b1;
                  remaining_n = remaining - 16'd1;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
                  if (remaining == 16'd1) state_n = S_CSUM;
`endif
               end
            end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (rx_shift == csum) begin
                  state_n = S_DONE;
                  hold_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  state_n = S_ERROR;
                  err_n   = 1'b1;
                  hold_n  = 1'b1;
               end
            end
`endif
            default: state_n = S_IDLE;
         endcase
      end
   end

   assign imem.imem_write_address = addr;
   assign imem.imem_write_data    = wdata;
   assign imem.imem_write_enable  = we;
   assign core_hold               = hold;
   assign load_done               = done;
   assign load_error              = err;
endmodule
